// File: rtl/seq_reg_arb_pkg.sv
// Shared types and the round-robin selection helper for seq_reg_write_arbiter.
// Latency: pure declarations plus one combinational function; no state.
// Backpressure: not applicable; the function only picks a winner among asserted valids.
package seq_reg_arb_pkg;

  // The one-entry commit stage is either empty or holding a write that lands next edge.
  typedef enum logic {
    COMMIT_EMPTY = 1'b0,
    COMMIT_FULL  = 1'b1
  } commit_state_e;

  // The helper works on the largest supported requester count; callers zero-extend.
  localparam int MAX_REQ   = 8;
  localparam int REQ_IDX_W = 3;

  typedef struct packed {
    logic                 found;
    logic [REQ_IDX_W-1:0] idx;
  } rr_pick_t;

  // Scan ptr, ptr+1, ... modulo n and return the first asserted valid.
  // ptr < n, so ptr+off never needs more than one subtraction to wrap.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]   valid,
                                       input logic [REQ_IDX_W-1:0] ptr,
                                       input int                   n);
    rr_pick_t r;
    int       idx;
    r = '0;
    for (int off = 0; off < MAX_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= n) idx = idx - n;
      if (!r.found && (off < n) && valid[idx[REQ_IDX_W-1:0]]) begin
        r.found = 1'b1;
        r.idx   = idx[REQ_IDX_W-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_rr_picker.sv
// Combinational round-robin select: first asserted valid at or after ptr (wrapping).
// Latency: zero cycles, purely combinational.
// Backpressure: none; found=0 when no requester is valid.
// Ports: valid_i (per-requester request), ptr_i (priority start index),
//        found_o (some requester is valid), winner_o (selected index).
module seq_rr_picker
  import seq_reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic               found_o,
  output logic [PTR_W-1:0]   winner_o
);

  logic [MAX_REQ-1:0]   valid_ext;
  logic [REQ_IDX_W-1:0] ptr_ext;
  rr_pick_t             pick;

  always_comb begin
    valid_ext = MAX_REQ'(valid_i);
    ptr_ext   = REQ_IDX_W'(ptr_i);
    pick      = rr_pick(valid_ext, ptr_ext, NUM_REQ);
    found_o   = pick.found;
    winner_o  = PTR_W'(pick.idx);
  end

endmodule

// File: rtl/seq_reg_write_arbiter.sv
// Round-robin write arbiter feeding a one-entry commit stage in front of a register bank.
// Latency: accept edge latches the write, the following edge loads the register (2 edges to q).
// Backpressure: one accept per cycle is always sustainable; req_ready only drops under reset or with no valid.
// Ports: clk/rst (sync, active-high); req_valid/req_addr/req_data packed per requester;
//        req_ready one-hot accept strobe; q packed register contents; busy = commit pending;
//        grant_id = last accepted requester.
// Optional: define SEQ_ARB_LOCK_EN to add req_lock, which holds priority on the last winner.
module seq_reg_write_arbiter
  import seq_reg_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 2,
  parameter  int WIDTH    = 8,
  parameter  int NUM_REGS = 4,
  localparam int ADDR_W   = $clog2(NUM_REGS),
  localparam int GID_W    = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef SEQ_ARB_LOCK_EN
  input  logic                        req_lock,
`endif
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REGS*WIDTH-1:0]   q,
  output logic                        busy,
  output logic [GID_W-1:0]            grant_id
);

  commit_state_e     state_q, state_d;
  logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
  logic [WIDTH-1:0]  pend_data_q, pend_data_d;
  logic [GID_W-1:0]  ptr_q, ptr_d;
  logic [GID_W-1:0]  gid_q, gid_d;
  logic [WIDTH-1:0]  regs_q [NUM_REGS];

  logic              found;
  logic [GID_W-1:0]  winner;
  logic              accept;
  logic              hold_ptr;

  seq_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (GID_W)
  ) u_picker (
    .valid_i  (req_valid),
    .ptr_i    (ptr_q),
    .found_o  (found),
    .winner_o (winner)
  );

`ifdef SEQ_ARB_LOCK_EN
  assign hold_ptr = req_lock;
`else
  assign hold_ptr = 1'b0;
`endif

  // The commit stage drains every edge, so it can always take a new write;
  // the only thing that blocks an accept is reset.
  assign accept = found && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_d     = COMMIT_EMPTY;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    ptr_d       = ptr_q;
    gid_d       = gid_q;
    if (accept) begin
      state_d     = COMMIT_FULL;
      pend_addr_d = req_addr[int'(winner)*ADDR_W +: ADDR_W];
      pend_data_d = req_data[int'(winner)*WIDTH +: WIDTH];
      gid_d       = winner;
      if (hold_ptr) begin
        // Locked: the winner stays at the head of the search order.
        ptr_d = winner;
      end else if (winner == GID_W'(NUM_REQ-1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = winner + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COMMIT_EMPTY;
      pend_addr_q <= '0;
      pend_data_q <= '0;
      ptr_q       <= '0;
      gid_q       <= '0;
      for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      ptr_q       <= ptr_d;
      gid_q       <= gid_d;
      for (int k = 0; k < NUM_REGS; k++) begin
        if ((state_q == COMMIT_FULL) && (pend_addr_q == ADDR_W'(k))) begin
          regs_q[k] <= pend_data_q;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_q
    assign q[k*WIDTH +: WIDTH] = regs_q[k];
  end

  assign busy     = (state_q == COMMIT_FULL);
  assign grant_id = gid_q;

endmodule

// File: tb/tb_seq_reg_write_arbiter.sv
module tb_seq_reg_write_arbiter;

  localparam int NR   = 2;
  localparam int W    = 8;
  localparam int NREG = 4;
  localparam int AW   = 2;
  localparam int GW   = 1;
`ifdef SEQ_ARB_LOCK_EN
  localparam bit LOCK_BUILT = 1'b1;
`else
  localparam bit LOCK_BUILT = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               lk;
  logic [NR-1:0]      req_valid;
  logic [NR*AW-1:0]   req_addr;
  logic [NR*W-1:0]    req_data;
  logic [NR-1:0]      req_ready;
  logic [NREG*W-1:0]  q;
  logic               busy;
  logic [GW-1:0]      grant_id;

  always #5 clk = ~clk;

  seq_reg_write_arbiter #(.NUM_REQ(NR), .WIDTH(W), .NUM_REGS(NREG)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SEQ_ARB_LOCK_EN
    .req_lock  (lk),
`endif
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .q         (q),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  // Reference model: register array, a queue of writes waiting to land, pointer, last grant.
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } wr_t;

  logic [W-1:0] m_regs [NREG];
  wr_t          m_pend [$];
  int           m_ptr;
  int           m_gid;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [NR-1:0] obs_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, compare all outputs
  // against the model, then advance the model across the rising edge.
  task automatic step(input logic r, input logic [NR-1:0] v,
                      input logic [NR*AW-1:0] a, input logic [NR*W-1:0] d,
                      input logic l);
    logic [NR-1:0]     exp_ready;
    logic [NREG*W-1:0] exp_q;
    int                win;
    int                idx;
    wr_t               p;
    @(negedge clk);
    rst = r; req_valid = v; req_addr = a; req_data = d; lk = l;
    #1;
    exp_ready = '0;
    win = 0;
    if (!r) begin
      for (int off = 0; off < NR; off++) begin
        idx = (m_ptr + off) % NR;
        if (exp_ready == '0 && v[idx]) begin
          exp_ready[idx] = 1'b1;
          win = idx;
        end
      end
    end
    for (int k = 0; k < NREG; k++) exp_q[k*W +: W] = m_regs[k];
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("busy", 64'(busy), 64'(m_pend.size() != 0));
    check("q", 64'(q), 64'(exp_q));
    check("grant_id", 64'(grant_id), 64'(m_gid));
    obs_ready = req_ready;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < NREG; k++) m_regs[k] = '0;
      m_pend.delete();
      m_ptr = 0;
      m_gid = 0;
    end else begin
      if (m_pend.size() != 0) begin
        p = m_pend.pop_front();
        m_regs[p.addr] = p.data;
      end
      if (exp_ready != '0) begin
        p.addr = a[win*AW +: AW];
        p.data = d[win*W +: W];
        m_pend.push_back(p);
        m_gid = win;
        m_ptr = (LOCK_BUILT && l) ? win : (win + 1) % NR;
      end
    end
  endtask

  task automatic step2(input logic r, input logic [1:0] v,
                       input logic [AW-1:0] a0, input logic [W-1:0] d0,
                       input logic [AW-1:0] a1, input logic [W-1:0] d1,
                       input logic l);
    step(r, v, {a1, a0}, {d1, d0}, l);
  endtask

  logic [NR-1:0]    hv;
  logic [NR*AW-1:0] ha;
  logic [NR*W-1:0]  hd;

  initial begin
    for (int k = 0; k < NREG; k++) m_regs[k] = '0;
    m_ptr = 0; m_gid = 0;
    rst = 1'b1; req_valid = '0; req_addr = '0; req_data = '0; lk = 1'b0;

    // Reset, then idle with nothing requested.
    step2(1, 2'b00, 0, 0, 0, 0, 0);
    step2(1, 2'b11, 1, 8'h01, 2, 8'h02, 0);
    check("ready_in_reset", 64'(obs_ready), 64'h0);
    step2(0, 2'b00, 0, 0, 0, 0, 0);
    step2(0, 2'b00, 0, 0, 0, 0, 0);
    check("idle_q", 64'(q), 64'h0);

    // Single write: req 0 -> addr 2 = A5.
    step2(0, 2'b01, 2, 8'hA5, 0, 0, 0);
    check("single_ready", 64'(obs_ready), 64'h1);
    step2(0, 2'b00, 0, 0, 0, 0, 0);
    check("single_busy", 64'(busy), 64'h1);
    step2(0, 2'b00, 0, 0, 0, 0, 0);
    check("single_q2", 64'(q[2*W +: W]), 64'hA5);
    check("single_idle_busy", 64'(busy), 64'h0);

    // Contention from ptr=0: grants alternate 0,1,0,1; waiting requester holds its data.
    step2(1, 2'b00, 0, 0, 0, 0, 0);
    step2(0, 2'b11, 0, 8'h40, 3, 8'h50, 0);
    check("cont_g0", 64'(obs_ready), 64'h1);
    step2(0, 2'b11, 0, 8'h41, 3, 8'h50, 0);
    check("cont_g1", 64'(obs_ready), 64'h2);
    step2(0, 2'b11, 0, 8'h41, 3, 8'h51, 0);
    check("cont_g2", 64'(obs_ready), 64'h1);
    step2(0, 2'b11, 0, 8'h42, 3, 8'h51, 0);
    check("cont_g3", 64'(obs_ready), 64'h2);
    step2(0, 2'b00, 0, 0, 0, 0, 0);
    step2(0, 2'b00, 0, 0, 0, 0, 0);
    check("cont_q", 64'(q), 64'h5100_0041);

    // Same address on consecutive cycles: last accepted wins.
    step2(0, 2'b10, 0, 0, 0, 8'h11, 0);
    step2(0, 2'b01, 0, 8'h22, 0, 0, 0);
    step2(0, 2'b00, 0, 0, 0, 0, 0);
    step2(0, 2'b00, 0, 0, 0, 0, 0);
    check("same_addr_q0", 64'(q[W-1:0]), 64'h22);

    // Reset on the commit edge discards the pending write.
    step2(0, 2'b10, 0, 0, 1, 8'hFF, 0);
    step2(1, 2'b00, 0, 0, 0, 0, 0);
    step2(0, 2'b00, 0, 0, 0, 0, 0);
    check("rst_mid_q1", 64'(q[2*W-1:W]), 64'h0);
    check("rst_mid_busy", 64'(busy), 64'h0);
    check("rst_mid_gid", 64'(grant_id), 64'h0);
    step2(0, 2'b11, 1, 8'h33, 2, 8'h44, 0);
    check("rst_mid_ptr0", 64'(obs_ready), 64'h1);

`ifdef SEQ_ARB_LOCK_EN
    // Lock keeps req 0 on top; the third accept drops lock so rotation resumes.
    step2(1, 2'b00, 0, 0, 0, 0, 0);
    step2(0, 2'b11, 0, 8'h61, 1, 8'h71, 1);
    check("lock_g0", 64'(obs_ready), 64'h1);
    step2(0, 2'b11, 0, 8'h62, 1, 8'h71, 1);
    check("lock_g1", 64'(obs_ready), 64'h1);
    step2(0, 2'b11, 0, 8'h63, 1, 8'h71, 0);
    check("lock_g2", 64'(obs_ready), 64'h1);
    step2(0, 2'b11, 0, 8'h64, 1, 8'h71, 0);
    check("lock_release", 64'(obs_ready), 64'h2);
`endif

    // Randomized traffic: requesters hold their write until it is accepted.
    hv = '0; ha = '0; hd = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NR; i++) begin
        if (!hv[i] && ($urandom_range(0, 3) != 0)) begin
          hv[i] = 1'b1;
          ha[i*AW +: AW] = AW'($urandom_range(0, NREG-1));
          hd[i*W +: W]   = W'($urandom);
        end
      end
      step(($urandom_range(0, 49) == 0), hv, ha, hd, ($urandom_range(0, 2) == 0));
      hv = hv & ~obs_ready;
    end
    step2(0, 2'b00, 0, 0, 0, 0, 0);
    step2(0, 2'b00, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
